// File: rtl/bus_arbiter_rr_pkg.sv
// rtl/bus_arbiter_rr_pkg.sv - shared types, defaults and helpers for the round-robin bus arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CNT_W   = 8;

    // Index width for n items; never below one bit so a 1-bit id is always legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// rtl/bus_arbiter_rr_if.sv - request/grant bundle between the masters and the arbiter
interface bus_arbiter_rr_if
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS = 4
);
    localparam int ID_W = clog2(N_MASTERS);

    logic [N_MASTERS-1:0] req_n;
    logic [N_MASTERS-1:0] grant_n;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_pulse_n;
    logic                 bus_idle;
    logic                 timeout_err;

    modport master (
        output req_n,
        input  grant_n,
        input  grant_id,
        input  grant_pulse_n,
        input  bus_idle,
        input  timeout_err
    );

    modport slave (
        input  req_n,
        output grant_n,
        output grant_id,
        output grant_pulse_n,
        output bus_idle,
        output timeout_err
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// rtl/bus_arbiter_rr_picker.sv - combinational round-robin winner select (rotate, priority-encode, unrotate)
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [ID_W-1:0] winner_o,
    output logic            valid_o
);

    logic [N-1:0]    rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0]   sum;

    always_comb begin
        // Doubling the vector turns the wrap-around rotate into a plain shift.
        rot = N'({req_i, req_i} >> ptr_i);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
            end
        end
        sum = {1'b0, off} + {1'b0, ptr_i};
        if (sum >= (ID_W + 1)'(N)) begin
            sum = sum - (ID_W + 1)'(N);
        end
        winner_o = sum[ID_W-1:0];
        valid_o  = |req_i;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin serial-bus arbiter with turnaround; forced release under ARB_TIMEOUT_EN
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    bus_arbiter_rr_if.slave   bus
);

    localparam int ID_W = clog2(N_MASTERS);

    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [N_MASTERS-1:0] grant_n_q, grant_n_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 pulse_n_q, pulse_n_d;
    logic [ID_W-1:0]      winner;
    logic                 win_valid;
    logic                 owner_req;
    logic [ID_W-1:0]      ptr_next;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 terr_q, terr_d;
`endif

    rr_picker #(
        .N    (N_MASTERS),
        .ID_W (ID_W)
    ) u_picker (
        .req_i    (~bus.req_n),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .valid_o  (win_valid)
    );

    assign owner_req = ~bus.req_n[grant_id_q];
    assign ptr_next  = (grant_id_q == ID_W'(N_MASTERS - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_n_d  = grant_n_q;
        grant_id_d = grant_id_q;
        pulse_n_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        terr_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_n_d  = ~(N_MASTERS'(1) << winner);
                    grant_id_d = winner;
                    pulse_n_d  = 1'b0;
                    state_d    = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ST_GRANT: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`endif
                // A voluntary release wins over a same-edge timeout.
                if (!owner_req) begin
                    grant_n_d = '1;
                    ptr_d     = ptr_next;
                    state_d   = ST_TURN;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    grant_n_d = '1;
                    ptr_d     = ptr_next;
                    terr_d    = 1'b1;
                    state_d   = ST_TURN;
                end
`endif
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                grant_n_d = '1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_n_q  <= '1;
            grant_id_q <= '0;
            pulse_n_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= '0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_n_q  <= grant_n_d;
            grant_id_q <= grant_id_d;
            pulse_n_q  <= pulse_n_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            terr_q     <= terr_d;
`endif
        end
    end

    assign bus.grant_n       = grant_n_q;
    assign bus.grant_id      = grant_id_q;
    assign bus.grant_pulse_n = pulse_n_q;
    assign bus.bus_idle      = (state_q == ST_IDLE);
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout_err   = terr_q;
`else
    assign bus.timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed self-checking bench for bus_arbiter_rr
module tb_bus_arbiter_rr;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    bit clk = 1'b0;
    logic rstn;
    int total = 0;
    int bad   = 0;

    bus_arbiter_rr_if #(.N_MASTERS(4)) bus ();

    bus_arbiter_rr #(
        .N_MASTERS (4),
        .TIMEOUT   (TMO),
        .CNT_W     (8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] gn, input int id);
        check({tag, "_grant_n"}, 32'(bus.grant_n), 32'(gn));
        if (gn != 4'b1111) begin
            check({tag, "_grant_id"}, 32'(bus.grant_id), 32'(id));
        end
    endtask

    initial begin
        rstn        = 1'b0;
        bus.req_n   = 4'b1111;
        step(2);
        check("rst_grant_n", 32'(bus.grant_n), 32'hF);
        check("rst_grant_id", 32'(bus.grant_id), 32'h0);
        check("rst_pulse_n", 32'(bus.grant_pulse_n), 32'h1);
        check("rst_idle", 32'(bus.bus_idle), 32'h1);
        check("rst_terr", 32'(bus.timeout_err), 32'h0);
        rstn = 1'b1;
        step(1);

        // Single request from master 1, held five grant cycles.
        bus.req_n = 4'b1101;
        step(1);
        check_grant("single", 4'b1101, 1);
        check("single_pulse_first", 32'(bus.grant_pulse_n), 32'h0);
        check("single_idle_busy", 32'(bus.bus_idle), 32'h0);
        step(1);
        check("single_pulse_second", 32'(bus.grant_pulse_n), 32'h1);
        check_grant("single_hold", 4'b1101, 1);
        step(3);
        bus.req_n = 4'b1111;
        step(1);
        check_grant("single_turn", 4'b1111, 0);
        check("single_turn_idle", 32'(bus.bus_idle), 32'h0);
        step(1);
        check("single_idle_back", 32'(bus.bus_idle), 32'h1);
        check_grant("single_idle", 4'b1111, 0);

        // Move pointer to 3 via a master-2 tenure, then wrap 3 -> 0.
        bus.req_n = 4'b1011;
        step(1);
        check_grant("m2", 4'b1011, 2);
        bus.req_n = 4'b1111;
        step(2);
        bus.req_n = 4'b0110;
        step(1);
        check_grant("wrap_first", 4'b0111, 3);
        step(1);
        bus.req_n = 4'b1110;
        step(1);
        check_grant("wrap_turn", 4'b1111, 0);
        step(1);
        check("wrap_idle", 32'(bus.bus_idle), 32'h1);
        step(1);
        check_grant("wrap_second", 4'b1110, 0);
        check("wrap_pulse", 32'(bus.grant_pulse_n), 32'h0);
        bus.req_n = 4'b1111;
        step(2);

        // Asynchronous reset in the middle of a master-2 tenure (pointer is 1).
        bus.req_n = 4'b1011;
        step(1);
        check_grant("pre_rst", 4'b1011, 2);
        step(1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_grant_n", 32'(bus.grant_n), 32'hF);
        check("async_rst_idle", 32'(bus.bus_idle), 32'h1);
        check("async_rst_pulse", 32'(bus.grant_pulse_n), 32'h1);
        bus.req_n = 4'b0000;
        step(1);
        rstn = 1'b1;
        step(1);

        // All masters requesting, each holding three cycles: 0,1,2,3,0,1.
        for (int k = 0; k < 5; k++) begin
            check_grant($sformatf("rr%0d", k), ~(4'b0001 << (k % 4)), k % 4);
            check($sformatf("rr%0d_pulse", k), 32'(bus.grant_pulse_n), 32'h0);
            step(1);
            check($sformatf("rr%0d_onehot", k), 32'($countones(~bus.grant_n)), 32'h1);
            step(1);
            bus.req_n[k % 4] = 1'b1;
            step(1);
            check_grant($sformatf("rr%0d_turn", k), 4'b1111, 0);
            bus.req_n[k % 4] = 1'b0;
            step(1);
            check($sformatf("rr%0d_idle", k), 32'(bus.bus_idle), 32'h1);
            step(1);
        end
        check_grant("rr5", 4'b1101, 1);

        // Master 1 keeps requesting; master 2 joins after the grant.
        bus.req_n = 4'b1111;
        step(2);
        bus.req_n = 4'b1101;
        step(1);
        check_grant("hold_start", 4'b1101, 1);
        bus.req_n = 4'b1001;
`ifdef ARB_TIMEOUT_EN
        step(7);
        check_grant("tmo_last", 4'b1101, 1);
        check("tmo_last_terr", 32'(bus.timeout_err), 32'h0);
        step(1);
        check_grant("tmo_forced", 4'b1111, 0);
        check("tmo_terr", 32'(bus.timeout_err), 32'h1);
        step(1);
        check("tmo_terr_clear", 32'(bus.timeout_err), 32'h0);
        check("tmo_idle", 32'(bus.bus_idle), 32'h1);
        step(1);
        check_grant("tmo_next", 4'b1011, 2);
`else
        for (int c = 0; c < 300; c++) begin
            step(1);
            check("hold_grant_n", 32'(bus.grant_n), 32'hD);
            check("hold_terr", 32'(bus.timeout_err), 32'h0);
        end
        bus.req_n = 4'b1011;
        step(1);
        check_grant("hold_release", 4'b1111, 0);
        step(2);
        check_grant("hold_next", 4'b1011, 2);
`endif
        bus.req_n = 4'b1111;
        step(3);
        check("end_idle", 32'(bus.bus_idle), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
